// File: rtl/pbs_pkg.sv
// Shared definitions for the battle-turn scheduler: state encodings,
// trainer identifiers and default datapath widths.
package pbs_pkg;

    localparam logic [3:0] PBS_IDLE    = 4'd0;
    localparam logic [3:0] PBS_ORDER   = 4'd1;
    localparam logic [3:0] PBS_ATK1    = 4'd2;
    localparam logic [3:0] PBS_CHK1    = 4'd3;
    localparam logic [3:0] PBS_ATK2    = 4'd4;
    localparam logic [3:0] PBS_CHK2    = 4'd5;
    localparam logic [3:0] PBS_VICTORY = 4'd6;
    localparam logic [3:0] PBS_LOSS    = 4'd7;

    typedef enum logic [3:0] {
        ST_IDLE    = PBS_IDLE,
        ST_ORDER   = PBS_ORDER,
        ST_ATK1    = PBS_ATK1,
        ST_CHK1    = PBS_CHK1,
        ST_ATK2    = PBS_ATK2,
        ST_CHK2    = PBS_CHK2,
        ST_VICTORY = PBS_VICTORY,
        ST_LOSS    = PBS_LOSS
    } pbs_state_e;

    localparam logic TRAINER_PLAYER = 1'b0;
    localparam logic TRAINER_AI     = 1'b1;

    localparam int PBS_HP_W      = 8;
    localparam int PBS_SPD_W     = 8;
    localparam int PBS_MOVE_W    = 2;
    localparam int PBS_TURN_W    = 6;
    localparam int PBS_MAX_TURNS = 32;

endpackage

// File: rtl/pbs_turn_order.sv
// Attack-order decision: unsigned speed compare with an alternating
// tie-breaker. The tie flag only advances when a tie is resolved.
module pbs_turn_order
    import pbs_pkg::*;
#(
    parameter int SPD_W = PBS_SPD_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic [SPD_W-1:0] i_p_speed,
    input  logic [SPD_W-1:0] i_ai_speed,
    output logic             o_first_is_ai
);

    logic r_tie_flag;
    logic w_tie;
    logic w_ai_faster;

    assign w_tie         = (i_ai_speed == i_p_speed);
    assign w_ai_faster   = (i_ai_speed > i_p_speed);
    assign o_first_is_ai = i_en & (w_tie ? r_tie_flag : w_ai_faster);

    // Alternate who goes first on successive speed ties.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tie_flag <= 1'b0;
        end else if (i_en && w_tie) begin
            r_tie_flag <= ~r_tie_flag;
        end
    end

endmodule

// File: rtl/pbs_turn_scheduler.sv
// Battle-turn sequencer: latches both trainers' choices on a confirm edge,
// orders the two attacks by speed, drives the damage datapath twice per
// turn and ends the battle when a target faints.
// Optional turn limit enabled by defining TURN_LIMIT_EN.
//
// state   | meaning
// IDLE    | waiting for confirm; checks for an already-fainted side
// ORDER   | decide attack order
// ATK1    | first attacker's damage request, waits for dp_done
// CHK1    | faint check on first target
// ATK2    | second attacker's damage request, waits for dp_done
// CHK2    | faint check on second target, turn bookkeeping
// VICTORY | battle won, terminal
// LOSS    | battle lost, terminal
module pbs_turn_scheduler
    import pbs_pkg::*;
#(
    parameter int HP_W      = PBS_HP_W,
    parameter int SPD_W     = PBS_SPD_W,
    parameter int MOVE_W    = PBS_MOVE_W,
    parameter int TURN_W    = PBS_TURN_W,
    parameter int MAX_TURNS = PBS_MAX_TURNS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [MOVE_W-1:0] p_move,
    input  logic [MOVE_W-1:0] ai_move,
    input  logic [SPD_W-1:0]  p_speed,
    input  logic [SPD_W-1:0]  ai_speed,
    input  logic [HP_W-1:0]   p_hp,
    input  logic [HP_W-1:0]   ai_hp,
    input  logic              dp_done,
    output logic              apply_damage,
    output logic              active_trainer,
    output logic              target,
    output logic [MOVE_W-1:0] move_sel,
    output logic              busy,
    output logic              victory,
    output logic              loss,
    output logic [TURN_W-1:0] turn_count,
    output logic [3:0]        state_dbg
);

`ifdef TURN_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    pbs_state_e        r_state;
    logic              r_go_q;
    logic [MOVE_W-1:0] r_p_move;
    logic [MOVE_W-1:0] r_ai_move;
    logic [SPD_W-1:0]  r_p_speed;
    logic [SPD_W-1:0]  r_ai_speed;
    logic              r_first_is_ai;
    logic              r_apply;
    logic              r_active;
    logic              r_target;
    logic [MOVE_W-1:0] r_move_sel;
    logic              r_busy;
    logic              r_victory;
    logic              r_loss;
    logic [TURN_W-1:0] r_turn_count;

    pbs_state_e        w_state_nxt;
    logic              w_first_nxt;
    logic [TURN_W-1:0] w_tc_nxt;
    logic              w_order_first;
    logic              w_go_rise;
    logic              w_tgt1_faint;
    logic              w_tgt2_faint;
    logic              w_limit_hit;
    logic              w_attacker;
    logic              w_apply_nxt;

    assign w_go_rise    = go & ~r_go_q;
    assign w_tgt1_faint = (r_first_is_ai == TRAINER_AI) ? (p_hp == '0) : (ai_hp == '0);
    assign w_tgt2_faint = (r_first_is_ai == TRAINER_AI) ? (ai_hp == '0) : (p_hp == '0);
    assign w_limit_hit  = LIMIT_ON && ((int'(r_turn_count) + 1) == MAX_TURNS);

    pbs_turn_order #(
        .SPD_W(SPD_W)
    ) u_order (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_en         (r_state == ST_ORDER),
        .i_p_speed    (r_p_speed),
        .i_ai_speed   (r_ai_speed),
        .o_first_is_ai(w_order_first)
    );

    // Next-state and turn bookkeeping; outputs are decoded from the next
    // state so they arrive registered together with the state they belong to.
    always_comb begin
        w_state_nxt = r_state;
        w_first_nxt = r_first_is_ai;
        w_tc_nxt    = r_turn_count;
        case (r_state)
            ST_IDLE: begin
                if (p_hp == '0)        w_state_nxt = ST_LOSS;
                else if (ai_hp == '0)  w_state_nxt = ST_VICTORY;
                else if (w_go_rise)    w_state_nxt = ST_ORDER;
            end
            ST_ORDER: begin
                w_first_nxt = w_order_first;
                w_state_nxt = ST_ATK1;
            end
            ST_ATK1: begin
                if (dp_done) w_state_nxt = ST_CHK1;
            end
            ST_CHK1: begin
                if (w_tgt1_faint)
                    w_state_nxt = (r_first_is_ai == TRAINER_AI) ? ST_LOSS : ST_VICTORY;
                else
                    w_state_nxt = ST_ATK2;
            end
            ST_ATK2: begin
                if (dp_done) w_state_nxt = ST_CHK2;
            end
            ST_CHK2: begin
                if (w_tgt2_faint) begin
                    w_state_nxt = (r_first_is_ai == TRAINER_AI) ? ST_VICTORY : ST_LOSS;
                end else begin
                    w_tc_nxt = (&r_turn_count) ? r_turn_count : r_turn_count + 1'b1;
                    if (w_limit_hit)
                        w_state_nxt = (ai_hp < p_hp) ? ST_VICTORY : ST_LOSS;
                    else
                        w_state_nxt = ST_IDLE;
                end
            end
            ST_VICTORY, ST_LOSS: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_apply_nxt = (w_state_nxt == ST_ATK1) || (w_state_nxt == ST_ATK2);
        w_attacker  = (w_state_nxt == ST_ATK1) ? w_first_nxt : ~w_first_nxt;
    end

    // State, latched turn inputs and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_go_q        <= 1'b0;
            r_p_move      <= '0;
            r_ai_move     <= '0;
            r_p_speed     <= '0;
            r_ai_speed    <= '0;
            r_first_is_ai <= 1'b0;
            r_apply       <= 1'b0;
            r_active      <= 1'b0;
            r_target      <= 1'b0;
            r_move_sel    <= '0;
            r_busy        <= 1'b0;
            r_victory     <= 1'b0;
            r_loss        <= 1'b0;
            r_turn_count  <= '0;
        end else begin
            r_go_q        <= go;
            r_state       <= w_state_nxt;
            r_first_is_ai <= w_first_nxt;
            r_turn_count  <= w_tc_nxt;
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_ORDER)) begin
                r_p_move   <= p_move;
                r_ai_move  <= ai_move;
                r_p_speed  <= p_speed;
                r_ai_speed <= ai_speed;
            end
            r_apply    <= w_apply_nxt;
            r_active   <= w_apply_nxt ? w_attacker : 1'b0;
            r_target   <= w_apply_nxt ? ~w_attacker : 1'b0;
            r_move_sel <= w_apply_nxt ? ((w_attacker == TRAINER_AI) ? r_ai_move : r_p_move) : '0;
            r_busy     <= !((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_VICTORY) ||
                            (w_state_nxt == ST_LOSS));
            r_victory  <= (w_state_nxt == ST_VICTORY);
            r_loss     <= (w_state_nxt == ST_LOSS);
        end
    end

    assign apply_damage   = r_apply;
    assign active_trainer = r_active;
    assign target         = r_target;
    assign move_sel       = r_move_sel;
    assign busy           = r_busy;
    assign victory        = r_victory;
    assign loss           = r_loss;
    assign turn_count     = r_turn_count;
    assign state_dbg      = r_state;

endmodule

// File: tb/tb_pbs_turn_scheduler.sv
// Self-checking bench for pbs_turn_scheduler: per-cycle expectations are
// queued as stimulus is driven and compared on the falling clock edge.
module tb_pbs_turn_scheduler;
    import pbs_pkg::*;

    localparam int HP_W   = 8;
    localparam int SPD_W  = 8;
    localparam int MOVE_W = 2;
    localparam int TURN_W = 6;
`ifdef TURN_LIMIT_EN
    localparam int MT  = 2;
    localparam bit LIM = 1'b1;
`else
    localparam int MT  = 32;
    localparam bit LIM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              go = 1'b0;
    logic [MOVE_W-1:0] p_move = '0;
    logic [MOVE_W-1:0] ai_move = '0;
    logic [SPD_W-1:0]  p_speed = '0;
    logic [SPD_W-1:0]  ai_speed = '0;
    logic [HP_W-1:0]   p_hp = 8'd100;
    logic [HP_W-1:0]   ai_hp = 8'd100;
    logic              dp_done = 1'b0;
    logic              apply_damage;
    logic              active_trainer;
    logic              target;
    logic [MOVE_W-1:0] move_sel;
    logic              busy;
    logic              victory;
    logic              loss;
    logic [TURN_W-1:0] turn_count;
    logic [3:0]        state_dbg;

    pbs_turn_scheduler #(
        .HP_W(HP_W), .SPD_W(SPD_W), .MOVE_W(MOVE_W), .TURN_W(TURN_W), .MAX_TURNS(MT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .p_move(p_move), .ai_move(ai_move),
        .p_speed(p_speed), .ai_speed(ai_speed), .p_hp(p_hp), .ai_hp(ai_hp),
        .dp_done(dp_done), .apply_damage(apply_damage), .active_trainer(active_trainer),
        .target(target), .move_sel(move_sel), .busy(busy), .victory(victory),
        .loss(loss), .turn_count(turn_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        st;
        logic              ap;
        logic              act;
        logic              tgt;
        logic [MOVE_W-1:0] ms;
        logic              bsy;
        logic              vic;
        logic              los;
        logic [TURN_W-1:0] tc;
    } exp_t;

    typedef struct {
        logic [SPD_W-1:0]  ps;
        logic [SPD_W-1:0]  as;
        logic [MOVE_W-1:0] pm;
        logic [MOVE_W-1:0] am;
        int                w1;
        bit                rst_before;
        bit                exp_first_ai;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_tc = 0;

    function automatic exp_t mk(input logic [3:0] st, input logic atk, input int tc);
        exp_t e;
        e.st  = st;
        e.ap  = (st == PBS_ATK1) || (st == PBS_ATK2);
        e.act = e.ap ? atk : 1'b0;
        e.tgt = e.ap ? ~atk : 1'b0;
        e.ms  = e.ap ? (atk ? ai_move : p_move) : '0;
        e.bsy = !((st == PBS_IDLE) || (st == PBS_VICTORY) || (st == PBS_LOSS));
        e.vic = (st == PBS_VICTORY);
        e.los = (st == PBS_LOSS);
        e.tc  = TURN_W'(tc);
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Scoreboard: one expectation per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state_dbg", state_dbg, e.st);
            chk("apply_damage", apply_damage, e.ap);
            chk("active_trainer", active_trainer, e.act);
            chk("target", target, e.tgt);
            chk("move_sel", move_sel, e.ms);
            chk("busy", busy, e.bsy);
            chk("victory", victory, e.vic);
            chk("loss", loss, e.los);
            chk("turn_count", turn_count, e.tc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        go      = 1'b0;
        dp_done = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        m_tc    = 0;
        sb.push_back(mk(PBS_IDLE, 1'b0, 0));
    endtask

    // One complete turn; ATK1 waits w1 cycles before dp_done.
    task automatic run_turn(input vec_t v);
        int         n;
        logic [3:0] end_st;
        p_speed  = v.ps;
        ai_speed = v.as;
        p_move   = v.pm;
        ai_move  = v.am;
        n = 6 + v.w1;
        for (int k = 0; k <= n; k++) begin
            step();
            go      = (k <= 2);
            dp_done = (k == 1) || ((k >= 2 + v.w1) && (k <= 4 + v.w1));
            if (k == 0)                sb.push_back(mk(PBS_IDLE, 1'b0, m_tc));
            else if (k == 1)           sb.push_back(mk(PBS_ORDER, 1'b0, m_tc));
            else if (k <= 2 + v.w1)    sb.push_back(mk(PBS_ATK1, v.exp_first_ai, m_tc));
            else if (k == 3 + v.w1)    sb.push_back(mk(PBS_CHK1, 1'b0, m_tc));
            else if (k == 4 + v.w1)    sb.push_back(mk(PBS_ATK2, ~v.exp_first_ai, m_tc));
            else if (k == 5 + v.w1)    sb.push_back(mk(PBS_CHK2, 1'b0, m_tc));
            else begin
                if (LIM && (m_tc + 1 == MT))
                    end_st = (ai_hp < p_hp) ? PBS_VICTORY : PBS_LOSS;
                else
                    end_st = PBS_IDLE;
                if (m_tc < (1 << TURN_W) - 1) m_tc++;
                sb.push_back(mk(end_st, 1'b0, m_tc));
            end
        end
        go      = 1'b0;
        dp_done = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{ps: 8'd50,  as: 8'd30,  pm: 2'd2, am: 2'd1, w1: 0, rst_before: 1, exp_first_ai: 0};
        vecs[1] = '{ps: 8'd40,  as: 8'd60,  pm: 2'd3, am: 2'd0, w1: 3, rst_before: 1, exp_first_ai: 1};
        vecs[2] = '{ps: 8'd45,  as: 8'd45,  pm: 2'd1, am: 2'd2, w1: 0, rst_before: 1, exp_first_ai: 0};
        vecs[3] = '{ps: 8'd45,  as: 8'd45,  pm: 2'd1, am: 2'd2, w1: 1, rst_before: 0, exp_first_ai: 1};
        vecs[4] = '{ps: 8'h7F,  as: 8'h80,  pm: 2'd0, am: 2'd3, w1: 0, rst_before: 1, exp_first_ai: 1};
        vecs[5] = '{ps: 8'hFF,  as: 8'h01,  pm: 2'd3, am: 2'd1, w1: 2, rst_before: 1, exp_first_ai: 0};

        p_hp  = 8'd100;
        ai_hp = 8'd100;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rst_before) do_reset();
            run_turn(vecs[i]);
        end

        // Target faints at CHK1: victory, ATK2 skipped, go/dp_done ignored.
        p_hp = 8'd100; ai_hp = 8'd100;
        p_speed = 8'd50; ai_speed = 8'd30; p_move = 2'd2; ai_move = 2'd1;
        do_reset();
        step(); go = 1'b1;                sb.push_back(mk(PBS_IDLE, 1'b0, 0));
        step(); go = 1'b0;                sb.push_back(mk(PBS_ORDER, 1'b0, 0));
        step(); dp_done = 1'b1;           sb.push_back(mk(PBS_ATK1, 1'b0, 0));
        step(); dp_done = 1'b0; ai_hp = '0; sb.push_back(mk(PBS_CHK1, 1'b0, 0));
        step();                           sb.push_back(mk(PBS_VICTORY, 1'b0, 0));
        for (int i = 0; i < 4; i++) begin
            step(); go = ~go; dp_done = 1'b1; sb.push_back(mk(PBS_VICTORY, 1'b0, 0));
        end
        go = 1'b0; dp_done = 1'b0;

        // Both sides at zero in IDLE: loss has precedence and is terminal.
        p_hp = 8'd100; ai_hp = 8'd100;
        do_reset();
        step(); p_hp = '0; ai_hp = '0;    sb.push_back(mk(PBS_IDLE, 1'b0, 0));
        step(); p_hp = 8'd50;             sb.push_back(mk(PBS_LOSS, 1'b0, 0));
        step(); go = 1'b1;                sb.push_back(mk(PBS_LOSS, 1'b0, 0));
        step(); go = 1'b0;                sb.push_back(mk(PBS_LOSS, 1'b0, 0));

        // Reset during ATK2 aborts the turn on the next cycle.
        p_hp = 8'd100; ai_hp = 8'd100;
        p_speed = 8'd40; ai_speed = 8'd60; p_move = 2'd1; ai_move = 2'd3;
        do_reset();
        step(); go = 1'b1;                sb.push_back(mk(PBS_IDLE, 1'b0, 0));
        step(); go = 1'b0;                sb.push_back(mk(PBS_ORDER, 1'b0, 0));
        step(); dp_done = 1'b1;           sb.push_back(mk(PBS_ATK1, 1'b1, 0));
        step();                           sb.push_back(mk(PBS_CHK1, 1'b0, 0));
        step(); dp_done = 1'b0; reset_n = 1'b0; sb.push_back(mk(PBS_ATK2, 1'b0, 0));
        step(); reset_n = 1'b1;           sb.push_back(mk(PBS_IDLE, 1'b0, 0));
        step();                           sb.push_back(mk(PBS_IDLE, 1'b0, 0));

`ifdef TURN_LIMIT_EN
        p_hp = 8'd10; ai_hp = 8'd5;
        do_reset();
        run_turn(vecs[0]);
        run_turn(vecs[0]);
        p_hp = 8'd10; ai_hp = 8'd10;
        do_reset();
        run_turn(vecs[0]);
        run_turn(vecs[0]);
`else
        // Long run to reach the saturating turn counter.
        p_hp = 8'd100; ai_hp = 8'd100;
        do_reset();
        for (int i = 0; i < 66; i++) run_turn(vecs[0]);
`endif

        step();
        step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
